car_frame_scheduler: RTL and testbench



---
 rtl/car_frame_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_car_frame_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_frame_scheduler.sv
// car_frame_scheduler: owns the car positions and runs the per-frame update
// for the VGA display. On each accepted frame tick it may advance every car
// one column. It then checks each car against the latched frog cell, one car
// per cycle, so a single adder and a single comparator are shared by all cars.
// The sequencer updates the lives count and the sticky game_over flag.
// Optional build macro SCHED_OVERRUN_CNT_EN adds overrun_cnt. This counter
// counts frame ticks that were dropped because an update was in progress.
module car_frame_scheduler #(
    parameter int NUM_CARS  = 16,
    parameter int GRID_COLS = 20,
    parameter int FIRST_ROW = 2,
    parameter int MOVE_DIV  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  enable,
    input  logic [4:0]            frog_col,
    input  logic [3:0]            frog_row,
    output logic [5*NUM_CARS-1:0] car_x_flat,
    output logic [4*NUM_CARS-1:0] car_y_flat,
    output logic [1:0]            lives,
    output logic                  game_over,
    output logic                  busy,
    output logic                  update_done,
    output logic                  collision
`ifdef SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]            overrun_cnt
`endif
);

    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, DONE} state_t;

    // Starting column of car i: the lanes are staggered by three columns.
    // The two cars in a lane are placed ten columns apart.
    function automatic logic [4:0] init_x(input int i);
        int v;
        v = ((i >> 1) * 3 + (((i % 2) == 1) ? 10 : 0)) % GRID_COLS;
        return 5'(v);
    endfunction

    state_t           state_reg;
    logic [IDX_W-1:0] k_reg;
    logic [DIV_W-1:0] div_reg;
    logic [4:0]       car_x_reg [NUM_CARS];
    logic [4:0]       frog_col_reg;
    logic [3:0]       frog_row_reg;
    logic             hit_reg;
    logic [1:0]       lives_reg;
    logic             game_over_reg;
    logic             busy_reg;
    logic             update_done_reg;
    logic             collision_reg;

    logic [4:0]       cur_x;
    logic [4:0]       moved_x;
    logic [3:0]       cur_row;
    logic             match;
    logic             last_idx;
    logic             accept;

    // Shared datapath: one car selected by k_reg gets one step and one compare.
    always_comb begin
        cur_x    = car_x_reg[k_reg];
        cur_row  = 4'(FIRST_ROW) + 4'(k_reg >> 1);
        moved_x  = cur_x;
        if (k_reg[1 % IDX_W] == 1'b0 || IDX_W == 1) begin
            // even lane: move left, column 0 wraps to the right edge
            moved_x = (cur_x == 5'd0) ? 5'(GRID_COLS - 1) : cur_x - 5'd1;
        end else begin
            // odd lane: move right, the right edge wraps to column 0
            moved_x = (cur_x == 5'(GRID_COLS - 1)) ? 5'd0 : cur_x + 5'd1;
        end
        match    = (cur_x == frog_col_reg) && (cur_row == frog_row_reg);
        last_idx = (k_reg == IDX_W'(NUM_CARS - 1));
        accept   = frame_tick && enable && !game_over_reg && (state_reg == IDLE);
    end

    // Update sequencer: moves and checks cars serially, then settles lives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            div_reg         <= DIV_W'(MOVE_DIV - 1);
            frog_col_reg    <= '0;
            frog_row_reg    <= '0;
            hit_reg         <= 1'b0;
            lives_reg       <= 2'd3;
            game_over_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            update_done_reg <= 1'b0;
            collision_reg   <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) begin
                car_x_reg[i] <= init_x(i);
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        frog_col_reg <= frog_col;
                        frog_row_reg <= frog_row;
                        hit_reg      <= 1'b0;
                        k_reg        <= '0;
                        busy_reg     <= 1'b1;
                        if (div_reg == '0) begin
                            div_reg   <= DIV_W'(MOVE_DIV - 1);
                            state_reg <= MOVE;
                        end else begin
                            div_reg   <= div_reg - 1'b1;
                            state_reg <= CHECK;
                        end
                    end
                end
                MOVE: begin
                    car_x_reg[k_reg] <= moved_x;
                    if (last_idx) begin
                        k_reg     <= '0;
                        state_reg <= CHECK;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                CHECK: begin
                    hit_reg <= hit_reg | match;
                    if (last_idx) begin
                        k_reg           <= '0;
                        update_done_reg <= 1'b1;
                        collision_reg   <= hit_reg | match;
                        state_reg       <= DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                DONE: begin
                    update_done_reg <= 1'b0;
                    collision_reg   <= 1'b0;
                    busy_reg        <= 1'b0;
                    state_reg       <= IDLE;
                    if (collision_reg && lives_reg != 2'd0) begin
                        lives_reg <= lives_reg - 2'd1;
                        if (lives_reg == 2'd1) begin
                            game_over_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SCHED_OVERRUN_CNT_EN
    logic [7:0] overrun_reg;

    // Count live ticks that arrive while a sequence is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= 8'd0;
        end else if (frame_tick && enable && !game_over_reg &&
                     state_reg != IDLE && overrun_reg != 8'hFF) begin
            overrun_reg <= overrun_reg + 8'd1;
        end
    end

    assign overrun_cnt = overrun_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CARS; gi++) begin : g_car_out
            assign car_x_flat[5*gi +: 5] = car_x_reg[gi];
            assign car_y_flat[4*gi +: 4] = 4'(FIRST_ROW + gi / 2);
        end
    endgenerate

    assign lives       = lives_reg;
    assign game_over   = game_over_reg;
    assign busy        = busy_reg;
    assign update_done = update_done_reg;
    assign collision   = collision_reg;

endmodule

// File: tb/tb_car_frame_scheduler.sv
// Directed testbench for car_frame_scheduler with the default parameters
// (16 cars, 20 columns, first row 2, move every 8 ticks).
module tb_car_frame_scheduler;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         frame_tick = 1'b0;
    logic         enable = 1'b1;
    logic [4:0]   frog_col = 5'd25;
    logic [3:0]   frog_row = 4'd15;
    logic [5*N-1:0] car_x_flat;
    logic [4*N-1:0] car_y_flat;
    logic [1:0]   lives;
    logic         game_over;
    logic         busy;
    logic         update_done;
    logic         collision;
`ifdef SCHED_OVERRUN_CNT_EN
    logic [7:0]   overrun_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    car_frame_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .enable      (enable),
        .frog_col    (frog_col),
        .frog_row    (frog_row),
        .car_x_flat  (car_x_flat),
        .car_y_flat  (car_y_flat),
        .lives       (lives),
        .game_over   (game_over),
        .busy        (busy),
        .update_done (update_done),
        .collision   (collision)
`ifdef SCHED_OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] car_x(input int i);
        return car_x_flat[5*i +: 5];
    endfunction

    // Check one value. The caller passes a name, the observed value and the
    // expected value; the name appears in the FAIL line.
    task automatic chk(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic apply_reset();
        frame_tick = 1'b0;
        enable     = 1'b1;
        frog_col   = 5'd25;
        frog_row   = 4'd15;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Pulse frame_tick for one cycle (cycle T). Then count cycles until
    // update_done is seen. The task returns at #1 inside the update_done cycle.
    task automatic do_tick(output int lat, output int busy_first);
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        busy_first = int'(busy);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (update_done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        chk("reset car0_x", int'(car_x(0)), 0);
        chk("reset car1_x", int'(car_x(1)), 10);
        chk("reset car2_x", int'(car_x(2)), 3);
        chk("reset car3_x", int'(car_x(3)), 13);
        chk("reset car15_x", int'(car_x(15)), 11);
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (car_y_flat[4*i +: 4] !== 4'(2 + i / 2)) begin
                tests_failed++;
                $display("FAIL reset car%0d_y: got %0d expected %0d", i, car_y_flat[4*i +: 4], 2 + i / 2);
            end
        end
        $display("ok   reset car_y table checked");
        chk("reset lives", int'(lives), 3);
        chk("reset busy", int'(busy), 0);
        chk("reset game_over", int'(game_over), 0);
        chk("reset update_done", int'(update_done), 0);
        chk("reset collision", int'(collision), 0);
    endtask

    task automatic test_divider();
        int lat, b1;
        apply_reset();
        for (int t = 1; t <= 7; t++) begin
            do_tick(lat, b1);
            chk($sformatf("check-only tick%0d latency", t), lat, 17);
            chk($sformatf("check-only tick%0d busy T+1", t), b1, 1);
            chk($sformatf("check-only tick%0d collision", t), int'(collision), 0);
            repeat (20) @(posedge clk);
            #1;
        end
        chk("car0_x before move", int'(car_x(0)), 0);
        do_tick(lat, b1);
        chk("move tick latency", lat, 33);
        chk("move tick busy T+1", b1, 1);
        chk("move car0_x wrap", int'(car_x(0)), 19);
        chk("move car1_x", int'(car_x(1)), 9);
        chk("move car2_x", int'(car_x(2)), 4);
        chk("move car3_x", int'(car_x(3)), 14);
        chk("move car15_x", int'(car_x(15)), 12);
        @(posedge clk);
        #1;
        chk("move done busy drop", int'(busy), 0);
        chk("move done pulse end", int'(update_done), 0);
        chk("move lives kept", int'(lives), 3);
    endtask

    task automatic test_collision();
        int lat, b1;
        apply_reset();
        frog_col = 5'd10;
        frog_row = 4'd2;
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        @(posedge clk);
        #1 frog_col = 5'd25;          // frog moves mid-sequence: ignored
        frog_row = 4'd15;
        lat = -1;
        for (int c = 2; c <= 100; c++) begin
            if (update_done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("collision latency", lat, 17);
        chk("collision pulse", int'(collision), 1);
        chk("collision lives before", int'(lives), 3);
        @(posedge clk);
        #1;
        chk("collision lives after", int'(lives), 2);
        chk("collision pulse end", int'(collision), 0);
        chk("collision game_over", int'(game_over), 0);
    endtask

    task automatic test_game_over();
        int lat, b1;
        int seen_busy;
        apply_reset();
        frog_col = 5'd10;
        frog_row = 4'd2;
        for (int t = 1; t <= 3; t++) begin
            do_tick(lat, b1);
            chk($sformatf("gameover frame%0d collision", t), int'(collision), 1);
            @(posedge clk);
            #1;
            chk($sformatf("gameover frame%0d lives", t), int'(lives), 3 - t);
            repeat (5) @(posedge clk);
            #1;
        end
        chk("game_over set", int'(game_over), 1);
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        seen_busy = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy === 1'b1 || update_done === 1'b1) seen_busy = 1;
            @(posedge clk);
            #1;
        end
        chk("game_over tick ignored", seen_busy, 0);
        chk("game_over car1 frozen", int'(car_x(1)), 10);
        chk("game_over lives floor", int'(lives), 0);
        chk("game_over sticky", int'(game_over), 1);
    endtask

    task automatic test_enable();
        int seen_busy;
        apply_reset();
        enable = 1'b0;
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        seen_busy = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy === 1'b1) seen_busy = 1;
            @(posedge clk);
            #1;
        end
        chk("disabled tick ignored", seen_busy, 0);
        enable = 1'b1;
    endtask

    task automatic test_busy_tick();
        int pulses, first_done;
        apply_reset();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        pulses = 0;
        first_done = -1;
        for (int c = 1; c <= 60; c++) begin
            if (update_done === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = c;
            end
            if (c == 4) frame_tick = 1'b1;
            if (c == 5) frame_tick = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("busy tick update_done count", pulses, 1);
        chk("busy tick latency", first_done, 17);
`ifdef SCHED_OVERRUN_CNT_EN
        chk("overrun_cnt", int'(overrun_cnt), 1);
`endif
    endtask

    task automatic test_reset_mid();
        int lat, b1;
        int pulse_seen;
        apply_reset();
        for (int t = 1; t <= 7; t++) begin
            do_tick(lat, b1);
            repeat (3) @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;         // now in T+1, MOVE k=0
        repeat (6) @(posedge clk);    // now in T+7, MOVE k=6
        #1;
        chk("mid-move car0 moved", int'(car_x(0)), 19);
        rst_n = 1'b0;
        #1;
        chk("mid-reset busy", int'(busy), 0);
        chk("mid-reset car0_x", int'(car_x(0)), 0);
        chk("mid-reset car2_x", int'(car_x(2)), 3);
        pulse_seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (update_done === 1'b1 || collision === 1'b1) pulse_seen = 1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (update_done === 1'b1 || collision === 1'b1 || busy === 1'b1) pulse_seen = 1;
            @(posedge clk);
            #1;
        end
        chk("mid-reset no pulse", pulse_seen, 0);
        chk("mid-reset lives", int'(lives), 3);
    endtask

    initial begin
        test_reset();
        test_divider();
        test_collision();
        test_game_over();
        test_enable();
        test_busy_tick();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: a stuck run still ends with a summary line.
    initial begin
        #2000000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

endmodule
